// File: rtl/fpu_bus_sequencer.sv
// fpu_bus_sequencer: host-side command engine for the 8-bit memory-mapped FPU.
// Accepts one request (A, B, opcode), writes it over the byte bus, starts the
// FPU, waits for cmd_end, reads back the 32-bit result, completes the end_ack
// handshake and presents the result on a valid/ready response port.
// Optional feature macro: FPU_SEQ_TIMEOUT_EN (watchdog on WAIT_END and ACK;
// expiry returns 32'hFFFFFFFF with rsp_err=1).
module fpu_bus_sequencer #(
  parameter int STROBE_CYCLES  = 1,
  parameter int OPCODE_W       = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_a,
  input  logic [31:0]         req_b,
  input  logic [OPCODE_W-1:0] req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_result,
  output logic                rsp_err,
  output logic                fpu_cs,
  output logic                fpu_rd,
  output logic                fpu_wr,
  output logic [3:0]          fpu_addr,
  output logic [7:0]          fpu_din,
  input  logic [7:0]          fpu_dout,
  input  logic                fpu_cmd_end,
  output logic                fpu_end_ack,
  output logic                seq_busy
);

  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_HOLD, WAIT_END, RD_SETUP, RD_WAIT, ACK, RESP
  } state_t;

  localparam logic [3:0] STRB_LAST = 4'(STROBE_CYCLES - 1);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15 || OPCODE_W < 1 || OPCODE_W > 8 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
    $error("fpu_bus_sequencer: parameter out of range");
  end

  state_t              state;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic [OPCODE_W-1:0] op_q;
  logic [3:0]          idx;
  logic [3:0]          strb_cnt;
  logic                to_fire;

  // Byte placed on the data bus for write register i (opcode zero-extended,
  // start register carries 0).
  function automatic logic [7:0] wr_byte(input logic [3:0]          i,
                                         input logic [31:0]         a,
                                         input logic [31:0]         b,
                                         input logic [OPCODE_W-1:0] op);
    logic [7:0] opx;
    opx = '0;
    opx[OPCODE_W-1:0] = op;
    case (i)
      4'd0:    wr_byte = a[7:0];
      4'd1:    wr_byte = a[15:8];
      4'd2:    wr_byte = a[23:16];
      4'd3:    wr_byte = a[31:24];
      4'd4:    wr_byte = b[7:0];
      4'd5:    wr_byte = b[15:8];
      4'd6:    wr_byte = b[23:16];
      4'd7:    wr_byte = b[31:24];
      4'd8:    wr_byte = opx;
      default: wr_byte = 8'h00;
    endcase
  endfunction

  // Operand capture at request acceptance; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      a_q  <= req_a;
      b_q  <= req_b;
      op_q <= req_op;
    end
  end

`ifdef FPU_SEQ_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_hit;

  // Watchdog count restarts on every entry to WAIT_END or ACK.
  always_ff @(posedge clk) begin
    if (arst || !(state == WAIT_END || state == ACK)) to_cnt <= '0;
    else                                               to_cnt <= to_cnt + 16'd1;
  end

  assign to_hit  = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign to_fire = to_hit && (((state == WAIT_END) && !fpu_cmd_end) ||
                              ((state == ACK) && fpu_cmd_end));

  // Error flag set by a watchdog expiry, cleared when the response is taken.
  always_ff @(posedge clk) begin
    if (arst)                           rsp_err <= 1'b0;
    else if (to_fire)                   rsp_err <= 1'b1;
    else if (state == RESP && rsp_ready) rsp_err <= 1'b0;
  end
`else
  assign to_fire = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Main sequencer: all bus and handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      seq_busy    <= 1'b0;
      fpu_cs      <= 1'b1;
      fpu_rd      <= 1'b1;
      fpu_wr      <= 1'b1;
      fpu_addr    <= 4'd0;
      fpu_din     <= 8'h00;
      fpu_end_ack <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 32'h0;
      idx         <= 4'd0;
      strb_cnt    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            seq_busy  <= 1'b1;
            idx       <= 4'd0;
            fpu_cs    <= 1'b0;
            fpu_wr    <= 1'b1;
            fpu_addr  <= 4'd0;
            fpu_din   <= wr_byte(4'd0, req_a, req_b, req_op);
            state     <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          fpu_wr   <= 1'b0;
          strb_cnt <= 4'd0;
          state    <= WR_STROBE;
        end
        WR_STROBE: begin
          if (strb_cnt == STRB_LAST) begin
            fpu_wr <= 1'b1;
            state  <= WR_HOLD;
          end else begin
            strb_cnt <= strb_cnt + 4'd1;
          end
        end
        WR_HOLD: begin
          if (idx == 4'd9) begin
            fpu_cs <= 1'b1;
            state  <= WAIT_END;
          end else begin
            idx      <= idx + 4'd1;
            fpu_addr <= idx + 4'd1;
            fpu_din  <= wr_byte(idx + 4'd1, a_q, b_q, op_q);
            state    <= WR_SETUP;
          end
        end
        WAIT_END: begin
          if (fpu_cmd_end) begin
            idx      <= 4'd0;
            fpu_cs   <= 1'b0;
            fpu_rd   <= 1'b0;
            fpu_addr <= 4'd9;
            state    <= RD_SETUP;
          end else if (to_fire) begin
            fpu_cs      <= 1'b1;
            fpu_rd      <= 1'b1;
            fpu_wr      <= 1'b1;
            fpu_end_ack <= 1'b0;
            rsp_result  <= 32'hFFFF_FFFF;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RD_SETUP: begin
          strb_cnt <= 4'd0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (strb_cnt == STRB_LAST) begin
            rsp_result[{idx[1:0], 3'b000} +: 8] <= fpu_dout;
            if (idx == 4'd3) begin
              fpu_cs      <= 1'b1;
              fpu_rd      <= 1'b1;
              fpu_end_ack <= 1'b1;
              state       <= ACK;
            end else begin
              idx      <= idx + 4'd1;
              fpu_addr <= fpu_addr + 4'd1;
              state    <= RD_SETUP;
            end
          end else begin
            strb_cnt <= strb_cnt + 4'd1;
          end
        end
        ACK: begin
          if (!fpu_cmd_end) begin
            fpu_end_ack <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (to_fire) begin
            fpu_cs      <= 1'b1;
            fpu_rd      <= 1'b1;
            fpu_wr      <= 1'b1;
            fpu_end_ack <= 1'b0;
            rsp_result  <= 32'hFFFF_FFFF;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            seq_busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_bus_sequencer.sv
// tb_fpu_bus_sequencer: directed bench with a behavioural byte-bus FPU model.
`timescale 1ns/1ps
module tb_fpu_bus_sequencer;

  localparam int         TO_CYC = 64;
  localparam logic [3:0] OP_ADD = 4'h1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_a, req_b, rsp_result;
  logic [3:0]  req_op;
  logic        fpu_cs, fpu_rd, fpu_wr, fpu_cmd_end, fpu_end_ack, seq_busy;
  logic [3:0]  fpu_addr;
  logic [7:0]  fpu_din, fpu_dout;

  fpu_bus_sequencer #(.STROBE_CYCLES(1), .OPCODE_W(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_cs(fpu_cs), .fpu_rd(fpu_rd), .fpu_wr(fpu_wr),
    .fpu_addr(fpu_addr), .fpu_din(fpu_din), .fpu_dout(fpu_dout),
    .fpu_cmd_end(fpu_cmd_end), .fpu_end_ack(fpu_end_ack),
    .seq_busy(seq_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- behavioural FPU model ----------------
  logic [31:0] m_result = 32'h0;
  int          m_lat    = 1;
  int          m_hold   = 1;
  bit          m_never  = 1'b0;
  bit          m_run;
  int          m_cnt, m_ack;
  logic        wr_d;
  logic [11:0] wlog[$];

  always @(posedge clk) begin
    wr_d <= fpu_wr;
    if (arst) begin
      fpu_cmd_end <= 1'b0;
      m_run       <= 1'b0;
      m_cnt       <= 0;
      m_ack       <= 0;
    end else begin
      if (!fpu_cs && !fpu_wr && wr_d === 1'b1) wlog.push_back({fpu_addr, fpu_din});
      if (!fpu_cs && !fpu_wr && fpu_addr == 4'd9) begin
        m_run <= 1'b1;
        m_cnt <= 0;
      end else if (m_run && !m_never) begin
        if (m_cnt >= m_lat) begin
          fpu_cmd_end <= 1'b1;
          m_run       <= 1'b0;
          m_ack       <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      if (fpu_cmd_end && fpu_end_ack) begin
        m_ack <= m_ack + 1;
        if (m_ack + 1 >= m_hold) fpu_cmd_end <= 1'b0;
      end
    end
  end

  always_comb begin
    fpu_dout = 8'h00;
    if (!fpu_cs && !fpu_rd) begin
      case (fpu_addr)
        4'd9:    fpu_dout = m_result[7:0];
        4'd10:   fpu_dout = m_result[15:8];
        4'd11:   fpu_dout = m_result[23:16];
        4'd12:   fpu_dout = m_result[31:24];
        default: fpu_dout = 8'h00;
      endcase
    end
  end

  // ---------------- helpers (stimulus / bounded waits only) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output bit ok);
    ok = 1'b0;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output bit ok);
    int c;
    ok = 1'b0;
    c  = 0;
    while (!ok && c < max) begin
      if (rsp_valid) ok = 1'b1;
      else begin tick(); c++; end
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    arst = 1'b1;
    tick();
    arst = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    tick(); tick();
    n_chk++; if ({fpu_cs, fpu_rd, fpu_wr, fpu_addr, fpu_din, fpu_end_ack} !== {3'b111, 4'h0, 8'h00, 1'b0})
      $display("FAIL reset_bus: got %h required %h", {fpu_cs, fpu_rd, fpu_wr, fpu_addr, fpu_din, fpu_end_ack}, {3'b111, 4'h0, 8'h00, 1'b0});
    else n_pass++;
    n_chk++; if ({rsp_valid, rsp_result, rsp_err} !== 34'h0)
      $display("FAIL reset_rsp: got %h required 0", {rsp_valid, rsp_result, rsp_err});
    else n_pass++;
    n_chk++; if ({req_ready, seq_busy} !== 2'b10)
      $display("FAIL reset_ctl: got %b required 10", {req_ready, seq_busy});
    else n_pass++;
    arst = 1'b0;
    tick();
  endtask

  task automatic test_add_bus();
    bit         ok;
    logic [7:0] exp_b [10];
    logic [11:0] got;
    exp_b = '{8'h0d, 8'h89, 8'h96, 8'h4d, 8'had, 8'h7f, 8'h44, 8'h4a, 8'h01, 8'h00};
    m_lat = 3; m_hold = 1; m_never = 1'b0; m_result = 32'h4d98120c;
    wlog.delete();
    issue(32'h4d96890d, 32'h4a447fad, OP_ADD, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL add_accept: accepted %b required 1", ok); else n_pass++;
    wait_rsp(400, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL add_rsp_valid: seen %b required 1", ok); else n_pass++;
    n_chk++; if (rsp_result !== 32'h4d98120c) $display("FAIL add_result: got %h required 4d98120c", rsp_result); else n_pass++;
    n_chk++; if (rsp_err !== 1'b0) $display("FAIL add_err: got %b required 0", rsp_err); else n_pass++;
    n_chk++; if (wlog.size() != 10) $display("FAIL add_wr_count: got %0d required 10", wlog.size()); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      got = (i < wlog.size()) ? wlog[i] : 12'hFFF;
      n_chk++; if (got !== {4'(i), exp_b[i]})
        $display("FAIL add_wr_byte%0d: got %h required %h", i, got, {4'(i), exp_b[i]});
      else n_pass++;
    end
    take_rsp();
    n_chk++; if ({rsp_valid, req_ready, seq_busy} !== 3'b010)
      $display("FAIL add_rsp_done: got %b required 010", {rsp_valid, req_ready, seq_busy});
    else n_pass++;
  endtask

  task automatic test_write_timing();
    bit ok;
    int k;
    m_lat = 1; m_result = 32'h43e43a5e;
    issue(32'h42f63efa, 32'h43a6aaa0, OP_ADD, ok);
    k = 0;
    while (ok && fpu_cs == 1'b0 && k < 100) begin tick(); k++; end
    n_chk++; if (k != 30) $display("FAIL wr_phase_len: got %0d cycles required 30", k); else n_pass++;
    wait_rsp(400, ok);
    n_chk++; if (!ok || rsp_result !== 32'h43e43a5e)
      $display("FAIL timing_result: got %h valid %b required 43e43a5e", rsp_result, ok);
    else n_pass++;
    take_rsp();
  endtask

  task automatic test_cmd_end_early();
    bit ok;
    int k, h;
    m_lat = 0; m_result = 32'hbf000000;
    issue(32'h3f800000, 32'hc0000000, OP_ADD, ok);
    k = 0;
    while (ok && fpu_cs == 1'b0 && k < 100) begin tick(); k++; end
    h = 0;
    while (fpu_cs == 1'b1 && h < 50) begin tick(); h++; end
    n_chk++; if (h != 1) $display("FAIL early_wait_len: got %0d cycles required 1", h); else n_pass++;
    n_chk++; if ({fpu_rd, fpu_addr} !== {1'b0, 4'd9})
      $display("FAIL early_rd_start: got %h required 09", {fpu_rd, fpu_addr});
    else n_pass++;
    wait_rsp(400, ok);
    n_chk++; if (!ok || rsp_result !== 32'hbf000000)
      $display("FAIL early_result: got %h valid %b required bf000000", rsp_result, ok);
    else n_pass++;
    take_rsp();
    m_lat = 1;
  endtask

  task automatic test_ack_hold();
    bit ok;
    int w, hi, cmd_hi;
    logic cmd_last;
    m_lat = 2; m_hold = 5; m_result = 32'h3f800000;
    issue(32'h3f000000, 32'h3f000000, OP_ADD, ok);
    w = 0;
    while (!fpu_end_ack && w < 400) begin tick(); w++; end
    hi = 0; cmd_hi = 0; cmd_last = 1'b1;
    while (fpu_end_ack && hi < 50) begin
      cmd_last = fpu_cmd_end;
      if (fpu_cmd_end) cmd_hi++;
      tick(); hi++;
    end
    n_chk++; if (hi != 6) $display("FAIL ack_len: got %0d cycles required 6", hi); else n_pass++;
    n_chk++; if (cmd_hi != 5) $display("FAIL ack_cmd_overlap: got %0d cycles required 5", cmd_hi); else n_pass++;
    n_chk++; if (cmd_last !== 1'b0) $display("FAIL ack_fall_order: cmd_end %b on last ack cycle required 0", cmd_last); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b1) $display("FAIL ack_rsp_follow: got %b required 1", rsp_valid); else n_pass++;
    n_chk++; if (rsp_result !== 32'h3f800000) $display("FAIL ack_result: got %h required 3f800000", rsp_result); else n_pass++;
    take_rsp();
    m_hold = 1;
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    m_lat = 1; m_hold = 1; m_result = 32'hc0490fdb;
    issue(32'hc0000000, 32'hbf90fdb0, OP_ADD, ok);
    wait_rsp(400, ok);
    req_a = 32'h11223344; req_b = 32'h55667788; req_op = 4'h2; req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hc0490fdb || req_ready !== 1'b0) bad++;
    end
    n_chk++; if (!ok || bad != 0) $display("FAIL bp_hold: %0d unstable cycles valid %b required 0", bad, ok); else n_pass++;
    m_result = 32'h0badf00d;
    take_rsp();
    n_chk++; if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL bp_handshake: got %b required 01", {rsp_valid, req_ready});
    else n_pass++;
    tick();
    req_valid = 1'b0;
    n_chk++; if ({req_ready, seq_busy, fpu_cs, fpu_din} !== {3'b010, 8'h44})
      $display("FAIL bp_second_accept: got %h required %h", {req_ready, seq_busy, fpu_cs, fpu_din}, {3'b010, 8'h44});
    else n_pass++;
    wait_rsp(400, ok);
    n_chk++; if (!ok || rsp_result !== 32'h0badf00d)
      $display("FAIL bp_second_result: got %h valid %b required 0badf00d", rsp_result, ok);
    else n_pass++;
    take_rsp();
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int w;
    m_lat = 1; m_result = 32'h12345678;
    issue(32'h01020304, 32'h05060708, OP_ADD, ok);
    w = 0;
    while (!(fpu_addr == 4'hB && !fpu_rd && !fpu_cs) && w < 400) begin tick(); w++; end
    n_chk++; if (w >= 400) $display("FAIL mid_find_byte2: waited %0d cycles required <400", w); else n_pass++;
    arst = 1'b1;
    tick();
    n_chk++; if ({fpu_cs, fpu_rd, fpu_wr, fpu_addr, fpu_din, fpu_end_ack} !== {3'b111, 4'h0, 8'h00, 1'b0})
      $display("FAIL mid_bus: got %h required %h", {fpu_cs, fpu_rd, fpu_wr, fpu_addr, fpu_din, fpu_end_ack}, {3'b111, 4'h0, 8'h00, 1'b0});
    else n_pass++;
    n_chk++; if ({rsp_valid, rsp_result, rsp_err, req_ready, seq_busy} !== {34'h0, 2'b10})
      $display("FAIL mid_ctl: got %h required %h", {rsp_valid, rsp_result, rsp_err, req_ready, seq_busy}, {34'h0, 2'b10});
    else n_pass++;
    arst = 1'b0;
    tick();
    m_result = 32'h40490fdb;
    issue(32'h40000000, 32'h3f90fdb0, OP_ADD, ok);
    wait_rsp(400, ok);
    n_chk++; if (!ok || rsp_result !== 32'h40490fdb)
      $display("FAIL mid_recover: got %h valid %b required 40490fdb", rsp_result, ok);
    else n_pass++;
    take_rsp();
  endtask

`ifdef FPU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int k, c;
    m_never = 1'b1;
    issue(32'h3f800000, 32'h3f800000, OP_ADD, ok);
    k = 0;
    while (ok && fpu_cs == 1'b0 && k < 100) begin tick(); k++; end
    c = 0;
    while (!rsp_valid && c < 200) begin tick(); c++; end
    n_chk++; if (c != TO_CYC) $display("FAIL to_len: got %0d cycles required %0d", c, TO_CYC); else n_pass++;
    n_chk++; if ({rsp_result, rsp_err} !== {32'hFFFFFFFF, 1'b1})
      $display("FAIL to_rsp: got %h required %h", {rsp_result, rsp_err}, {32'hFFFFFFFF, 1'b1});
    else n_pass++;
    n_chk++; if ({fpu_cs, fpu_rd, fpu_wr, fpu_end_ack} !== 4'b1110)
      $display("FAIL to_bus: got %b required 1110", {fpu_cs, fpu_rd, fpu_wr, fpu_end_ack});
    else n_pass++;
    take_rsp();
    n_chk++; if (rsp_err !== 1'b0) $display("FAIL to_err_clear: got %b required 0", rsp_err); else n_pass++;
    m_never = 1'b0;
    pulse_reset();
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    m_never = 1'b1;
    issue(32'h3f800000, 32'h3f800000, OP_ADD, ok);
    for (int i = 0; i < 300; i++) tick();
    n_chk++; if ({ok, rsp_valid, seq_busy, fpu_cs, rsp_err} !== 5'b10110)
      $display("FAIL no_to_wait: got %b required 10110", {ok, rsp_valid, seq_busy, fpu_cs, rsp_err});
    else n_pass++;
    m_never = 1'b0;
    pulse_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_add_bus();
    test_write_timing();
    test_cmd_end_early();
    test_ack_hold();
    test_backpressure();
    test_reset_mid_read();
`ifdef FPU_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "time limit");
  end

endmodule
